// File: rtl/vm_dispense_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vm_dispense_sequencer - pulses item motors per unit, then pays greedy change. Rev 1.0
// ----------------------------------------------------------------------------
module vm_dispense_sequencer #(
  parameter int MOTOR_CYCLES  = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int HOPPER_CYCLES = 2,
  parameter int TIMEOUT       = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [2:0] req_item_i,
  input  logic [1:0] req_amt_i,
  input  logic [5:0] req_chg_i,
  input  logic       drop_sense_i,
  output logic [4:0] motor_en_o,
  output logic [2:0] hop_en_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       fault_o,
  output logic [1:0] units_left_o,
  output logic [5:0] chg_left_o
);

  localparam int MAX_A = (MOTOR_CYCLES > GAP_CYCLES) ? MOTOR_CYCLES : GAP_CYCLES;
  localparam int MAX_B = (HOPPER_CYCLES > TIMEOUT) ? HOPPER_CYCLES : TIMEOUT;
  localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAXP > 1) ? $clog2(MAXP) : 1;

  // Counter is loaded with N-1 on entry so a state lasts exactly N cycles.
  localparam logic [CW-1:0] C_MOTOR = CW'(MOTOR_CYCLES - 1);
  localparam logic [CW-1:0] C_GAP   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] C_HOP   = CW'(HOPPER_CYCLES - 1);
  localparam logic [CW-1:0] C_TOUT  = CW'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_VEND_ON   = 3'd1;
  localparam logic [2:0] ST_VEND_WAIT = 3'd2;
  localparam logic [2:0] ST_VEND_GAP  = 3'd3;
  localparam logic [2:0] ST_CHG_ON    = 3'd4;
  localparam logic [2:0] ST_CHG_GAP   = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    item_q, item_d;
  logic [1:0]    units_q, units_d;
  logic [5:0]    chg_q, chg_d;
  logic          fault_q, fault_d;
  logic [4:0]    motor_q, motor_d;
  logic [2:0]    hop_q, hop_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;

  function automatic logic [2:0] pick_coin(input logic [5:0] c);
    if (c >= 6'd10)     pick_coin = 3'b100;
    else if (c >= 6'd5) pick_coin = 3'b010;
    else                pick_coin = 3'b001;
  endfunction

  function automatic logic [5:0] coin_value(input logic [2:0] h);
    case (h)
      3'b100:  coin_value = 6'd10;
      3'b010:  coin_value = 6'd5;
      3'b001:  coin_value = 6'd1;
      default: coin_value = 6'd0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    item_d  = item_q;
    units_d = units_q;
    chg_d   = chg_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          item_d = req_item_i;
          chg_d  = req_chg_i;
          if ((req_item_i <= 3'd4) && (req_amt_i != 2'd0)) begin
            units_d = req_amt_i;
            state_d = ST_VEND_ON;
            cnt_d   = C_MOTOR;
          end else begin
            units_d = 2'd0;
            if (req_chg_i != 6'd0) begin
              state_d = ST_CHG_ON;
              cnt_d   = C_HOP;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_VEND_ON: begin
        if (cnt_q == '0) begin
          state_d = ST_VEND_WAIT;
          cnt_d   = C_TOUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_VEND_WAIT: begin
        if (drop_sense_i) begin
          units_d = units_q - 2'd1;
          state_d = ST_VEND_GAP;
          cnt_d   = C_GAP;
        end else if (cnt_q == '0) begin
          // Remaining units are abandoned; change is still owed.
          fault_d = 1'b1;
          units_d = 2'd0;
          state_d = ST_VEND_GAP;
          cnt_d   = C_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_VEND_GAP: begin
        if (cnt_q == '0) begin
          if (units_q != 2'd0) begin
            state_d = ST_VEND_ON;
            cnt_d   = C_MOTOR;
          end else if (chg_q != 6'd0) begin
            state_d = ST_CHG_ON;
            cnt_d   = C_HOP;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CHG_ON: begin
        if (cnt_q == '0) begin
          chg_d   = chg_q - coin_value(hop_q);
          state_d = ST_CHG_GAP;
          cnt_d   = C_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CHG_GAP: begin
        if (cnt_q == '0) begin
          if (chg_q != 6'd0) begin
            state_d = ST_CHG_ON;
            cnt_d   = C_HOP;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    motor_d = (state_d == ST_VEND_ON) ? 5'(5'b00001 << item_d) : 5'b00000;
    hop_d   = (state_d == ST_CHG_ON) ? pick_coin(chg_d) : 3'b000;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      item_q  <= 3'd0;
      units_q <= 2'd0;
      chg_q   <= 6'd0;
      fault_q <= 1'b0;
      motor_q <= 5'd0;
      hop_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      item_q  <= item_d;
      units_q <= units_d;
      chg_q   <= chg_d;
      fault_q <= fault_d;
      motor_q <= motor_d;
      hop_q   <= hop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign motor_en_o   = motor_q;
  assign hop_en_o     = hop_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign fault_o      = fault_q;
  assign units_left_o = units_q;
  assign chg_left_o   = chg_q;

endmodule
`default_nettype wire

// File: tb/tb_vm_dispense_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vm_dispense_sequencer - directed + random orders against a cycle-budget model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_vm_dispense_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_item = 3'd0;
  logic [1:0] req_amt = 2'd0;
  logic [5:0] req_chg = 6'd0;
  logic       drop_sense = 1'b0;
  logic       req_ready, busy, done, fault;
  logic [4:0] motor_en;
  logic [2:0] hop_en;
  logic [1:0] units_left;
  logic [5:0] chg_left;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_fault = 1'b0;

  always #5 clk = ~clk;

  vm_dispense_sequencer #(
    .MOTOR_CYCLES (4),
    .GAP_CYCLES   (2),
    .HOPPER_CYCLES(2),
    .TIMEOUT      (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_item_i  (req_item),
    .req_amt_i   (req_amt),
    .req_chg_i   (req_chg),
    .drop_sense_i(drop_sense),
    .motor_en_o  (motor_en),
    .hop_en_o    (hop_en),
    .busy_o      (busy),
    .done_o      (done),
    .fault_o     (fault),
    .units_left_o(units_left),
    .chg_left_o  (chg_left)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int coin_of(input logic [2:0] h);
    case (h)
      3'b100:  return 10;
      3'b010:  return 5;
      3'b001:  return 1;
      default: return 99;
    endcase
  endfunction

  // Model: a unit costs 4+1+2 cycles when it drops, 4+16+2 on timeout; a coin 2+2.
  task automatic run_order(input string nm, input logic [2:0] it, input logic [1:0] am,
                           input logic [5:0] ch, input bit drop);
    bit vend;
    int c;
    int coins[$];
    int exp_chg[$];
    int obs_coin[$];
    int obs_chg[$];
    int exp_done, exp_pulses;
    logic [4:0] exp_mbit;
    int done_cyc = -1;
    int pulses = 0, mcyc = 0, wrong_m = 0, multi = 0, hcyc = 0;
    logic [4:0] pm = 5'd0;
    logic [2:0] ph = 3'd0;
    logic       fault_at_done = 1'bx;
    logic [1:0] units_at_done = 2'bxx;
    logic [5:0] chg_at_done = 6'bxxxxxx;

    vend = (it <= 3'd4) && (am != 2'd0);
    c = int'(ch);
    while (c != 0) begin
      exp_chg.push_back(c);
      if (c >= 10)     begin coins.push_back(10); c -= 10; end
      else if (c >= 5) begin coins.push_back(5);  c -= 5;  end
      else             begin coins.push_back(1);  c -= 1;  end
    end
    exp_pulses = vend ? (drop ? int'(am) : 1) : 0;
    exp_done   = (vend ? (drop ? 7 * int'(am) : 22) : 0) + 4 * coins.size() + 1;
    exp_mbit   = vend ? 5'(5'b00001 << it) : 5'd0;
    if (vend && !drop) exp_fault = 1'b1;

    @(negedge clk);
    chk({nm, ".ready_pre"}, 32'(req_ready), 1);
    req_valid  = 1'b1;
    req_item   = it;
    req_amt    = am;
    req_chg    = ch;
    drop_sense = drop;
    for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk({nm, ".busy_c1"}, 32'(busy), 1);
        chk({nm, ".ready_c1"}, 32'(req_ready), 0);
        chk({nm, ".units_c1"}, 32'(units_left), vend ? 32'(am) : 0);
        chk({nm, ".chg_c1"}, 32'(chg_left), 32'(ch));
        req_valid = 1'b0;
        req_item  = 3'($urandom);
        req_amt   = 2'($urandom);
        req_chg   = 6'($urandom);
      end
      if (motor_en != 5'd0) mcyc++;
      if (motor_en != 5'd0 && pm == 5'd0) pulses++;
      if (motor_en != 5'd0 && motor_en != exp_mbit) wrong_m++;
      if ($countones({motor_en, hop_en}) > 1) multi++;
      if (hop_en != 3'd0) hcyc++;
      if (hop_en != 3'd0 && ph == 3'd0) begin
        obs_coin.push_back(coin_of(hop_en));
        obs_chg.push_back(int'(chg_left));
      end
      pm = motor_en;
      ph = hop_en;
      if (done === 1'b1) begin
        done_cyc      = cyc;
        fault_at_done = fault;
        units_at_done = units_left;
        chg_at_done   = chg_left;
      end
    end
    chk({nm, ".done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({nm, ".motor_pulses"}, 32'(pulses), 32'(exp_pulses));
    chk({nm, ".motor_cycles"}, 32'(mcyc), 32'(4 * exp_pulses));
    chk({nm, ".motor_wrong"}, 32'(wrong_m), 0);
    chk({nm, ".multi_drive"}, 32'(multi), 0);
    chk({nm, ".hop_cycles"}, 32'(hcyc), 32'(2 * coins.size()));
    chk({nm, ".coin_count"}, 32'(obs_coin.size()), 32'(coins.size()));
    for (int i = 0; i < coins.size() && i < obs_coin.size(); i++) begin
      chk($sformatf("%s.coin%0d", nm, i), 32'(obs_coin[i]), 32'(coins[i]));
      chk($sformatf("%s.chg_before%0d", nm, i), 32'(obs_chg[i]), 32'(exp_chg[i]));
    end
    chk({nm, ".fault_done"}, 32'(fault_at_done), 32'(exp_fault));
    chk({nm, ".units_done"}, 32'(units_at_done), 0);
    chk({nm, ".chg_done"}, 32'(chg_at_done), 0);
    @(negedge clk);
    chk({nm, ".ready_after"}, 32'(req_ready), 1);
    chk({nm, ".busy_after"}, 32'(busy), 0);
    chk({nm, ".done_after"}, 32'(done), 0);
    chk({nm, ".fault_idle"}, 32'(fault), 32'(exp_fault));
  endtask

  initial begin
    // Power-on reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst.ready", 32'(req_ready), 1);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.fault", 32'(fault), 0);
    chk("rst.motor", 32'(motor_en), 0);
    chk("rst.hop", 32'(hop_en), 0);
    chk("rst.units", 32'(units_left), 0);
    chk("rst.chg", 32'(chg_left), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_order("normal", 3'd2, 2'd2, 6'd17, 1'b1);
    run_order("minimum", 3'd0, 2'd1, 6'd0, 1'b1);
    run_order("timeout", 3'd4, 2'd3, 6'd5, 1'b0);
    run_order("invalid", 3'd6, 2'd2, 6'd63, 1'b1);
    run_order("empty", 3'd1, 2'd0, 6'd0, 1'b0);

    // Back-to-back empty orders with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1;
    req_item  = 3'd3;
    req_amt   = 2'd0;
    req_chg   = 6'd0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      chk($sformatf("b2b.done%0d", cyc), 32'(done), 32'(cyc % 2));
      chk($sformatf("b2b.ready%0d", cyc), 32'(req_ready), 32'(1 - cyc % 2));
    end
    req_valid = 1'b0;

    // Reset in the middle of a payout.
    @(negedge clk);
    req_valid = 1'b1;
    req_item  = 3'd7;
    req_amt   = 2'd1;
    req_chg   = 6'd30;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst.pre_hop", 32'(hop_en), 32'(3'b100));
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.hop", 32'(hop_en), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.chg", 32'(chg_left), 0);
    chk("midrst.ready", 32'(req_ready), 1);
    chk("midrst.fault", 32'(fault), 0);
    exp_fault = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 30; n++) begin
      run_order($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
